// File: rtl/sprite_compositor.sv
// sprite_compositor: layers N_SPR rectangular sprites, a dashed centre net,
// an overlay layer and a background colour into registered RGB.
// Two-stage pixel pipeline: stage 1 runs the hit tests, stage 2 applies
// layer priority. Sprite attributes are taken from a shadow copy that is
// refreshed once per frame, at the first blanking line.
`timescale 1ns/1ps

module sprite_compositor #(
    parameter int N_SPR     = 4,
    parameter int COLOR_W   = 4,
    parameter int H_VIDEO   = 640,
    parameter int V_VIDEO   = 480,
    parameter int NET_EN    = 1,
    parameter int NET_W     = 12,
    parameter int NET_DASH  = 12,
    parameter int NET_PER   = 24,
    parameter logic [3*COLOR_W-1:0] NET_COLOR = '1
) (
    input  logic                         clk_0,
    input  logic                         rst,
    input  logic [9:0]                   pixel_x,
    input  logic [9:0]                   pixel_y,
    input  logic                         video_on,
    input  logic [10*N_SPR-1:0]          spr_x,
    input  logic [10*N_SPR-1:0]          spr_y,
    input  logic [10*N_SPR-1:0]          spr_w,
    input  logic [10*N_SPR-1:0]          spr_h,
    input  logic [N_SPR-1:0]             spr_en,
    input  logic [3*COLOR_W*N_SPR-1:0]   spr_color,
    input  logic [3*COLOR_W-1:0]         bg_color,
    input  logic                         ovl_pixel,
    input  logic                         ovl_only,
    input  logic [3*COLOR_W-1:0]         ovl_color,
    output logic [COLOR_W-1:0]           red,
    output logic [COLOR_W-1:0]           green,
    output logic [COLOR_W-1:0]           blue,
    output logic                         video_on_q
);

    localparam int RGB_W = 3 * COLOR_W;
    localparam int CNT_W = 5;

    // Net occupies the half-open column range [NET_X0, NET_X1).
    localparam logic [9:0]       NET_X0    = 10'(H_VIDEO / 2 - NET_W / 2);
    localparam logic [10:0]      NET_X1    = 11'(H_VIDEO / 2 - NET_W / 2 + NET_W);
    localparam logic [9:0]       V_LOAD    = 10'(V_VIDEO);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NET_PER - 1);
    localparam logic [CNT_W-1:0] CNT_DASH  = CNT_W'(NET_DASH);

    // ------------------------------------------------------------------
    // Shadow attribute registers
    // ------------------------------------------------------------------
    logic [10*N_SPR-1:0]  sh_x_q;
    logic [10*N_SPR-1:0]  sh_y_q;
    logic [10*N_SPR-1:0]  sh_w_q;
    logic [10*N_SPR-1:0]  sh_h_q;
    logic [N_SPR-1:0]     sh_en_q;
    logic [RGB_W*N_SPR-1:0] sh_color_q;

    logic shadow_load;

    // The swap happens at the start of the first line below the active area,
    // so the whole next frame sees one consistent attribute set.
    assign shadow_load = (pixel_x == 10'd0) && (pixel_y == V_LOAD);

    // Enable shadow: cleared by reset so no sprite shows before the first swap.
    always_ff @(posedge clk_0) begin
        // NOTE: clocked blocks use non-blocking assignments so every register
        // samples the values that were present before the edge.
        if (rst) begin
            sh_en_q <= '0;
        end else if (shadow_load) begin
            sh_en_q <= spr_en;
        end
    end

    // Geometry and colour shadows: loaded with the enables, never reset.
    always_ff @(posedge clk_0) begin
        // NOTE: these wide shadow registers deliberately have no reset; they
        // are only observed through sh_en_q, which is reset.
        if (shadow_load) begin
            sh_x_q     <= spr_x;
            sh_y_q     <= spr_y;
            sh_w_q     <= spr_w;
            sh_h_q     <= spr_h;
            sh_color_q <= spr_color;
        end
    end

    // ------------------------------------------------------------------
    // Centre-net line counter
    // ------------------------------------------------------------------
    // net_cnt_d is the count that belongs to the line of the current pixel,
    // so line 0 already sees zero on its first pixel.
    logic [CNT_W-1:0] net_cnt_q;
    logic [CNT_W-1:0] net_cnt_d;

    // Next line count: clear on the first pixel of a frame, step at each active line start.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        net_cnt_d = net_cnt_q;
        if (pixel_x == 10'd0) begin
            if (pixel_y == 10'd0) begin
                net_cnt_d = '0;
            end else if (pixel_y < V_LOAD) begin
                net_cnt_d = (net_cnt_q == CNT_LAST) ? '0 : net_cnt_q + 1'b1;
            end
        end
    end

    // Line counter register.
    always_ff @(posedge clk_0) begin
        if (rst) begin
            net_cnt_q <= '0;
        end else begin
            net_cnt_q <= net_cnt_d;
        end
    end

    logic net_hit_d;
    assign net_hit_d = (NET_EN != 0)
                    && (net_cnt_d < CNT_DASH)
                    && (pixel_x >= NET_X0)
                    && ({1'b0, pixel_x} < NET_X1);

    // ------------------------------------------------------------------
    // Stage 1: per-sprite hit tests on the shadow copy
    // ------------------------------------------------------------------
    logic [N_SPR-1:0] spr_hit;

    for (genvar g = 0; g < N_SPR; g++) begin : g_hit
        logic [10:0] x_end;
        logic [10:0] y_end;

        // 11-bit ends: a sprite running past column/line 1023 clips instead of wrapping.
        assign x_end = {1'b0, sh_x_q[10*g +: 10]} + {1'b0, sh_w_q[10*g +: 10]};
        assign y_end = {1'b0, sh_y_q[10*g +: 10]} + {1'b0, sh_h_q[10*g +: 10]};

        // Half-open intervals: zero width or height never hits.
        assign spr_hit[g] = sh_en_q[g]
                         && (pixel_x >= sh_x_q[10*g +: 10])
                         && ({1'b0, pixel_x} < x_end)
                         && (pixel_y >= sh_y_q[10*g +: 10])
                         && ({1'b0, pixel_y} < y_end);
    end

    logic             spr_any_d;
    logic [RGB_W-1:0] spr_rgb_d;

    // Priority pick among hit sprites: walking from the top index down lets the lowest index win.
    always_comb begin
        spr_any_d = 1'b0;
        spr_rgb_d = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (spr_hit[i]) begin
                spr_any_d = 1'b1;
                spr_rgb_d = sh_color_q[RGB_W*i +: RGB_W];
            end
        end
    end

    logic             s1_von_q;
    logic             s1_ovl_q;
    logic             s1_ovl_only_q;
    logic             s1_net_q;
    logic             s1_spr_q;
    logic [RGB_W-1:0] s1_spr_rgb_q;

    // Stage 1 register: hit results and the qualifiers that travel with the pixel.
    always_ff @(posedge clk_0) begin
        if (rst) begin
            s1_von_q      <= 1'b0;
            s1_ovl_q      <= 1'b0;
            s1_ovl_only_q <= 1'b0;
            s1_net_q      <= 1'b0;
            s1_spr_q      <= 1'b0;
            s1_spr_rgb_q  <= '0;
        end else begin
            s1_von_q      <= video_on;
            s1_ovl_q      <= ovl_pixel;
            s1_ovl_only_q <= ovl_only;
            s1_net_q      <= net_hit_d;
            s1_spr_q      <= spr_any_d;
            s1_spr_rgb_q  <= spr_rgb_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: layer priority and output register
    // ------------------------------------------------------------------
    logic [RGB_W-1:0] rgb_d;
    logic [RGB_W-1:0] rgb_q;
    logic             von_q;

    // Layer priority: blanking, overlay-only mode, overlay, sprites, net, background.
    always_comb begin
        rgb_d = bg_color;
        if (!s1_von_q) begin
            rgb_d = '0;
        end else if (s1_ovl_only_q) begin
            rgb_d = s1_ovl_q ? ovl_color : '0;
        end else if (s1_ovl_q) begin
            rgb_d = ovl_color;
        end else if (s1_spr_q) begin
            rgb_d = s1_spr_rgb_q;
        end else if (s1_net_q) begin
            rgb_d = NET_COLOR;
        end
    end

    // Output register: RGB and the matching video_on.
    always_ff @(posedge clk_0) begin
        if (rst) begin
            rgb_q <= '0;
            von_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            von_q <= s1_von_q;
        end
    end

    assign red        = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign green      = rgb_q[2*COLOR_W-1:COLOR_W];
    assign blue       = rgb_q[COLOR_W-1:0];
    assign video_on_q = von_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios with literal expectations,
// then randomized pixels, all checked every cycle against a reference model.
`timescale 1ns/1ps

module tb_sprite_compositor;

    localparam int N  = 4;
    localparam int VV = 480;
    localparam int HV = 640;
    localparam int NW = 12;
    localparam int ND = 12;
    localparam int NP = 24;
    localparam logic [11:0] BG  = 12'h123;
    localparam logic [11:0] OVL = 12'h0A5;
    localparam logic [11:0] NETC = 12'hFFF;

    logic        clk_0 = 1'b0;
    logic        rst;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on;
    logic [39:0] spr_x, spr_y, spr_w, spr_h;
    logic [3:0]  spr_en;
    logic [47:0] spr_color;
    logic [11:0] bg_color, ovl_color;
    logic        ovl_pixel, ovl_only;
    logic [3:0]  red, green, blue;
    logic        video_on_q;

    sprite_compositor dut (
        .clk_0      (clk_0),
        .rst        (rst),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_w      (spr_w),
        .spr_h      (spr_h),
        .spr_en     (spr_en),
        .spr_color  (spr_color),
        .bg_color   (bg_color),
        .ovl_pixel  (ovl_pixel),
        .ovl_only   (ovl_only),
        .ovl_color  (ovl_color),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .video_on_q (video_on_q)
    );

    always #5 clk_0 = ~clk_0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: rectangles as integer ranges, net from the number of
    // lines started since the top of the frame, modulo the net period.
    // ------------------------------------------------------------------
    int          m_sx[N], m_sy[N], m_sw[N], m_sh[N];
    bit          m_en[N];
    logic [11:0] m_col[N];
    int          m_lines;

    typedef struct packed {
        logic        von;
        logic        ovl;
        logic        ovl_only;
        logic        net;
        logic        spr;
        logic [11:0] scol;
    } pix_t;

    pix_t        m_pipe;
    logic [11:0] exp_rgb;
    logic        exp_vq;
    bit          cmp_en = 1'b0;

    always @(posedge clk_0) begin : model
        pix_t nxt;
        int   x, y, win;
        if (rst) begin
            for (int i = 0; i < N; i++) m_en[i] = 1'b0;
            m_lines = 0;
            m_pipe  = '0;
            exp_rgb = '0;
            exp_vq  = 1'b0;
            cmp_en  = 1'b1;
        end else begin
            // Output for the pixel accepted one cycle earlier.
            if (!m_pipe.von)         exp_rgb = '0;
            else if (m_pipe.ovl_only) exp_rgb = m_pipe.ovl ? ovl_color : 12'h000;
            else if (m_pipe.ovl)     exp_rgb = ovl_color;
            else if (m_pipe.spr)     exp_rgb = m_pipe.scol;
            else if (m_pipe.net)     exp_rgb = NETC;
            else                     exp_rgb = bg_color;
            exp_vq = m_pipe.von;

            // Accept the current pixel.
            x = int'(pixel_x);
            y = int'(pixel_y);
            if (x == 0 && y == 0)       m_lines = 0;
            else if (x == 0 && y < VV)  m_lines++;
            win = -1;
            for (int i = 0; i < N; i++)
                if (win < 0 && m_en[i] && x >= m_sx[i] && x < m_sx[i] + m_sw[i]
                    && y >= m_sy[i] && y < m_sy[i] + m_sh[i])
                    win = i;
            nxt.von      = video_on;
            nxt.ovl      = ovl_pixel;
            nxt.ovl_only = ovl_only;
            nxt.net      = ((m_lines % NP) < ND) && x >= HV/2 - NW/2 && x < HV/2 - NW/2 + NW;
            nxt.spr      = (win >= 0);
            nxt.scol     = (win >= 0) ? m_col[win] : 12'h000;
            m_pipe = nxt;

            if (x == 0 && y == VV) begin
                for (int i = 0; i < N; i++) begin
                    m_sx[i]  = int'(spr_x[i*10 +: 10]);
                    m_sy[i]  = int'(spr_y[i*10 +: 10]);
                    m_sw[i]  = int'(spr_w[i*10 +: 10]);
                    m_sh[i]  = int'(spr_h[i*10 +: 10]);
                    m_en[i]  = spr_en[i];
                    m_col[i] = spr_color[i*12 +: 12];
                end
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk_0) begin
        if (cmp_en)
            check("pixel", {19'd0, video_on_q, red, green, blue}, {19'd0, exp_vq, exp_rgb});
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    task automatic pix(input int x, input int y, input bit von);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        tick();
    endtask

    // Present one active pixel, then a blank one; after the second edge the
    // output register holds the result for the probed pixel.
    task automatic probe(input string name, input int x, input int y, input logic [11:0] exp);
        pix(x, y, 1'b1);
        pix(700, 500, 1'b0);
        check(name, {20'd0, red, green, blue}, {20'd0, exp});
    endtask

    task automatic load_frame();
        pix(0, VV, 1'b0);
        pix(0, 0, 1'b0);
    endtask

    task automatic set_spr(input int i, input int x, input int y, input int w, input int h,
                           input bit en, input logic [11:0] col);
        spr_x[i*10 +: 10]     = 10'(x);
        spr_y[i*10 +: 10]     = 10'(y);
        spr_w[i*10 +: 10]     = 10'(w);
        spr_h[i*10 +: 10]     = 10'(h);
        spr_en[i]             = en;
        spr_color[i*12 +: 12] = col;
    endtask

    initial begin
        rst = 1'b1;
        pixel_x = '0; pixel_y = '0; video_on = 1'b0;
        spr_x = '0; spr_y = '0; spr_w = '0; spr_h = '0; spr_en = '0; spr_color = '0;
        bg_color = BG; ovl_color = OVL; ovl_pixel = 1'b0; ovl_only = 1'b0;

        // Reset and first frame.
        tick();
        tick();
        check("reset_rgb", {20'd0, red, green, blue}, 32'd0);
        check("reset_von", {31'd0, video_on_q}, 32'd0);
        rst = 1'b0;
        pix(5, 5, 1'b0);
        set_spr(0, 100, 50, 16, 16, 1'b1, 12'hF00);
        load_frame();

        // Single sprite edges and latency.
        probe("bg_plain", 10, 10, BG);
        pix(100, 50, 1'b1);
        check("latency_1clk", {20'd0, red, green, blue}, 32'd0);
        pix(700, 500, 1'b0);
        check("latency_2clk", {20'd0, red, green, blue}, 32'hF00);
        probe("spr0_corner", 115, 65, 12'hF00);
        probe("spr0_right", 116, 50, BG);
        probe("spr0_below", 100, 66, BG);
        probe("spr0_left", 99, 50, BG);

        // Overlap and mid-frame change.
        set_spr(0, 195, 195, 10, 10, 1'b1, 12'hF00);
        set_spr(1, 190, 190, 20, 20, 1'b1, 12'h0F0);
        load_frame();
        probe("overlap", 200, 200, 12'hF00);
        probe("spr1_only", 207, 207, 12'h0F0);
        spr_en[0] = 1'b0;
        probe("mid_frame_hold", 200, 200, 12'hF00);
        load_frame();
        probe("next_frame", 200, 200, 12'h0F0);

        // Centre net across two periods.
        load_frame();
        for (int y = 0; y < 50; y++) begin
            pix(0, y, 1'b1);
            pix(313, y, 1'b1);
            pix(314, y, 1'b1);
            pix(325, y, 1'b1);
            pix(326, y, 1'b1);
            if (y == 5)  probe("net_lit", 320, 5, NETC);
            if (y == 15) probe("net_dark", 320, 15, BG);
            if (y == 30) begin
                probe("net_left", 314, 30, NETC);
                probe("net_past", 326, 30, BG);
            end
        end

        // Overlay modes.
        ovl_only = 1'b1; ovl_pixel = 1'b1;
        probe("ovl_only_on", 200, 200, OVL);
        ovl_pixel = 1'b0;
        probe("ovl_only_off", 200, 200, 12'h000);
        ovl_pixel = 1'b1;
        pix(200, 200, 1'b0);
        pix(700, 500, 1'b0);
        check("blank_ovl", {20'd0, red, green, blue}, 32'd0);
        ovl_only = 1'b0;
        probe("ovl_over_spr", 200, 200, OVL);
        ovl_pixel = 1'b0;

        // Right-edge clipping, zero width, mid-frame reset.
        set_spr(2, 1020, 100, 16, 4, 1'b1, 12'h00F);
        set_spr(3, 500, 100, 0, 5, 1'b1, 12'hFF0);
        load_frame();
        probe("clip_left", 1020, 100, 12'h00F);
        probe("clip_last", 1023, 103, 12'h00F);
        probe("clip_before", 1019, 100, BG);
        probe("clip_nowrap", 3, 100, BG);
        probe("clip_y_end", 1020, 104, BG);
        probe("zero_width", 500, 102, BG);
        pix(1021, 100, 1'b1);
        rst = 1'b1;
        pix(1022, 100, 1'b1);
        check("rst_mid_rgb", {20'd0, red, green, blue}, 32'd0);
        check("rst_mid_von", {31'd0, video_on_q}, 32'd0);
        pix(1022, 100, 1'b1);
        rst = 1'b0;
        probe("rst_hidden", 1020, 100, BG);
        load_frame();
        probe("rst_reload", 1020, 100, 12'h00F);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 7) == 0)
                        set_spr(i, $urandom_range(960, 1023), $urandom_range(0, 255),
                                $urandom_range(0, 80), $urandom_range(0, 80),
                                1'($urandom), 12'($urandom));
                    else
                        set_spr(i, $urandom_range(0, 255), $urandom_range(0, 255),
                                $urandom_range(0, 80), $urandom_range(0, 80),
                                1'($urandom), 12'($urandom));
                end
            end
            if ($urandom_range(0, 49) == 0)  bg_color  = 12'($urandom);
            if ($urandom_range(0, 49) == 0)  ovl_color = 12'($urandom);
            ovl_pixel = ($urandom_range(0, 9) == 0);
            ovl_only  = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 19))
                0:       pix(0, VV, 1'b0);
                1:       pix(0, $urandom_range(0, 40), 1'b1);
                2:       pix(0, 0, 1'b1);
                3:       pix($urandom_range(300, 340), $urandom_range(0, 255), 1'b1);
                4:       pix($urandom_range(960, 1023), $urandom_range(0, 255), 1'b1);
                default: pix($urandom_range(0, 255), $urandom_range(0, 255),
                             $urandom_range(0, 9) != 0);
            endcase
        end
        rst = 1'b0;
        pix(700, 500, 1'b0);
        pix(700, 500, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
